// File: rtl/rvfi_pkg.sv
// RVFI record types shared by the core's commit side and rvfi_serializer.
// RVFI_SERIALIZER_CYCLE_STAMP_EN adds a capture-cycle stamp to each serializer entry.
package rvfi_pkg;

    localparam int XLEN           = 64;
    localparam int RVFI_SER_SEQ_W = 64;

    typedef struct packed {
        logic              valid;
        logic [63:0]       order;
        logic [31:0]       insn;
        logic              trap;
        logic              halt;
        logic              intr;
        logic [1:0]        mode;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [XLEN-1:0]   rs1_rdata;
        logic [XLEN-1:0]   rs2_rdata;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rd_wdata;
        logic [XLEN-1:0]   pc_rdata;
        logic [XLEN-1:0]   pc_wdata;
        logic [XLEN-1:0]   mem_addr;
        logic [XLEN/8-1:0] mem_rmask;
        logic [XLEN/8-1:0] mem_wmask;
        logic [XLEN-1:0]   mem_rdata;
        logic [XLEN-1:0]   mem_wdata;
    } rvfi_instr_t;

    typedef struct packed {
        rvfi_instr_t               instr;
        logic [RVFI_SER_SEQ_W-1:0] seq;
`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
        logic [63:0]               cycle;
`endif
    } rvfi_ser_entry_t;

    // A port carries a record worth tracing when it retires or traps.
    function automatic logic is_captured(input rvfi_instr_t r);
        return r.valid | r.trap;
    endfunction

endpackage

// File: rtl/rvfi_ser_compact.sv
// Combinational compaction of the RVFI port vector: captured records are
// packed towards index 0 in port order and k reports how many there are.
module rvfi_ser_compact
    import rvfi_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2
) (
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]         rvfi,
    output rvfi_instr_t [NR_COMMIT_PORTS-1:0]         compacted,
    output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]      k
);

    localparam int K_W   = $clog2(NR_COMMIT_PORTS + 1);
    localparam int IDX_W = (NR_COMMIT_PORTS > 1) ? $clog2(NR_COMMIT_PORTS) : 1;

    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        int n;
        compacted = '0;
        n         = 0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            if (is_captured(rvfi[i])) begin
                compacted[IDX_W'(n)] = rvfi[i];
                n                    = n + 1;
            end
        end
        k = K_W'(n);
    end

endmodule

// File: rtl/rvfi_serializer.sv
// Multi-port RVFI to single-stream serializer with sequence tagging and overflow reporting.
// Define RVFI_SERIALIZER_CYCLE_STAMP_EN to add a per-record capture-cycle stamp on cycle_o.
module rvfi_serializer
    import rvfi_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0]   rvfi_i,
    output logic                                valid_o,
    input  logic                                ready_i,
    output rvfi_instr_t                         rvfi_o,
    output logic [RVFI_SER_SEQ_W-1:0]           seq_o,
    output logic [$clog2(DEPTH):0]              count_o,
    output logic                                overflow_o,
`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
    output logic [63:0]                         cycle_o,
`endif
    output logic [31:0]                         drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int K_W   = $clog2(NR_COMMIT_PORTS + 1);

    rvfi_instr_t [NR_COMMIT_PORTS-1:0] compacted;
    logic [K_W-1:0]                    k;
    rvfi_ser_entry_t                   wr_entry [NR_COMMIT_PORTS];
    rvfi_ser_entry_t                   mem [DEPTH];
    logic [PTR_W-1:0]                  head, tail;
    logic [RVFI_SER_SEQ_W-1:0]         seq_ctr;
    logic [CNT_W-1:0]                  k_ext;
    logic [32:0]                       drop_sum;
    logic                              fits, write, drop, pop;
`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
    logic [63:0]                       cycle_ctr;
`endif

    rvfi_ser_compact #(.NR_COMMIT_PORTS(NR_COMMIT_PORTS)) u_compact (
        .rvfi      (rvfi_i),
        .compacted (compacted),
        .k         (k)
    );

    // Space is judged on the registered occupancy only; a same-cycle pop frees nothing.
    assign k_ext    = CNT_W'(k);
    assign fits     = (count_o + k_ext) <= CNT_W'(DEPTH);
    assign write    = fits && (k != '0);
    assign drop     = !fits;
    assign valid_o  = (count_o != '0);
    assign pop      = valid_o & ready_i;
    assign drop_sum = {1'b0, drop_cnt_o} + 33'(k);

    always_comb begin
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            wr_entry[j].instr = compacted[j];
            wr_entry[j].seq   = seq_ctr + RVFI_SER_SEQ_W'(j);
`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
            wr_entry[j].cycle = cycle_ctr;
`endif
        end
    end

    // NOTE: storage has no reset; outputs are gated by valid_o, so stale contents never show.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NR_COMMIT_PORTS; j++) begin
            if (write && (K_W'(j) < k)) begin
                mem[tail + PTR_W'(j)] <= wr_entry[j];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head       <= '0;
            tail       <= '0;
            count_o    <= '0;
            seq_ctr    <= '0;
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            if (write) begin
                tail <= tail + PTR_W'(k);
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count_o <= count_o + (write ? k_ext : '0) - CNT_W'(pop);
            seq_ctr <= seq_ctr + RVFI_SER_SEQ_W'(k);
            if (drop) begin
                overflow_o <= 1'b1;
                drop_cnt_o <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
            end
        end
    end

`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_ctr <= '0;
        end else begin
            cycle_ctr <= cycle_ctr + 64'd1;
        end
    end

    assign cycle_o = valid_o ? mem[head].cycle : '0;
`endif

    assign rvfi_o = valid_o ? mem[head].instr : '0;
    assign seq_o  = valid_o ? mem[head].seq   : '0;

endmodule

// File: tb/tb_rvfi_serializer.sv
// Scoreboard bench for rvfi_serializer (NR_COMMIT_PORTS=2, DEPTH=16).
`timescale 1ns/1ps
module tb_rvfi_serializer;
    import rvfi_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 16;

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    rvfi_instr_t [NR-1:0] rvfi_i = '0;
    logic                 valid_o;
    logic                 ready_i = 1'b0;
    rvfi_instr_t          rvfi_o;
    logic [63:0]          seq_o;
    logic [4:0]           count_o;
    logic                 overflow_o;
    logic [31:0]          drop_cnt_o;
`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
    logic [63:0]          cycle_o;
`endif

    rvfi_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rvfi_i     (rvfi_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .rvfi_o     (rvfi_o),
        .seq_o      (seq_o),
        .count_o    (count_o),
        .overflow_o (overflow_o),
`ifdef RVFI_SERIALIZER_CYCLE_STAMP_EN
        .cycle_o    (cycle_o),
`endif
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [63:0] pc;
        logic        trap;
        logic [63:0] seq;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_count = 0;
    logic        model_ovf = 1'b0;
    logic [31:0] model_drop = '0;
    logic [63:0] model_seq = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic rvfi_instr_t mk(input logic v, input logic t, input logic [63:0] pc);
        rvfi_instr_t r;
        r          = '0;
        r.valid    = v;
        r.trap     = t;
        r.pc_rdata = pc;
        r.pc_wdata = pc + 64'd4;
        r.insn     = pc[31:0] ^ 32'h0000_0013;
        return r;
    endfunction

    // One cycle: check current outputs against the model, drive the next inputs, advance the model.
    task automatic step(input rvfi_instr_t p0, input rvfi_instr_t p1, input logic rdy);
        rvfi_instr_t ports [NR];
        exp_t        e;
        int          k;
        logic        fits;
        @(negedge clk_i);
        check("count", 64'(count_o), 64'(model_count));
        check("valid", 64'(valid_o), 64'(model_count != 0));
        check("overflow", 64'(overflow_o), 64'(model_ovf));
        check("drop_cnt", 64'(drop_cnt_o), 64'(model_drop));
        if (model_count != 0) begin
            e = sb[0];
            check("head_pc", rvfi_o.pc_rdata, e.pc);
            check("head_trap", 64'(rvfi_o.trap), 64'(e.trap));
            check("head_seq", seq_o, e.seq);
            if (rdy) void'(sb.pop_front());
        end
        rvfi_i[0] = p0;
        rvfi_i[1] = p1;
        ready_i   = rdy;
        ports[0]  = p0;
        ports[1]  = p1;
        k = 0;
        for (int i = 0; i < NR; i++) if (ports[i].valid || ports[i].trap) k++;
        fits = (model_count + k) <= DEPTH;
        if (fits) begin
            int j;
            j = 0;
            for (int i = 0; i < NR; i++) begin
                if (ports[i].valid || ports[i].trap) begin
                    e.pc   = ports[i].pc_rdata;
                    e.trap = ports[i].trap;
                    e.seq  = model_seq + 64'(j);
                    sb.push_back(e);
                    j++;
                end
            end
        end else begin
            model_ovf  = 1'b1;
            model_drop = (64'(model_drop) + 64'(k) > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : model_drop + 32'(k);
        end
        model_seq   = model_seq + 64'(k);
        model_count = model_count + (fits ? k : 0) - ((model_count != 0 && rdy) ? 1 : 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_overflow", 64'(overflow_o), 64'd0);
        check("rst_drop", 64'(drop_cnt_o), 64'd0);
        check("rst_seq", seq_o, 64'd0);
        check("rst_rvfi_zero", 64'(rvfi_o == '0), 64'd1);
        rvfi_i  = '0;
        ready_i = 1'b0;
        sb.delete();
        model_count = 0;
        model_ovf   = 1'b0;
        model_drop  = '0;
        model_seq   = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rvfi_instr_t idle;
        idle = '0;

        // Single record, immediate drain.
        do_reset();
        step(mk(1, 0, 64'h8000_0000), idle, 1'b1);
        repeat (3) step(idle, idle, 1'b1);

        // Two ports per cycle, program order preserved.
        do_reset();
        step(mk(1, 0, 64'h100), mk(1, 0, 64'h104), 1'b1);
        step(mk(1, 0, 64'h108), mk(1, 0, 64'h10C), 1'b1);
        repeat (5) step(idle, idle, 1'b1);

        // Idle port 0, trapping port 1 compacts to a single entry.
        do_reset();
        step(idle, mk(0, 1, 64'h200), 1'b1);
        repeat (3) step(idle, idle, 1'b1);

        // Fill to full, drop the ninth pair, hold, then drain and push once more.
        do_reset();
        for (int c = 0; c < 9; c++)
            step(mk(1, 0, 64'h1000 + 64'(16 * c)), mk(1, 0, 64'h1008 + 64'(16 * c)), 1'b0);
        repeat (5) step(idle, idle, 1'b0);
        check("full_count", 64'(count_o), 64'd16);
        check("full_overflow", 64'(overflow_o), 64'd1);
        check("full_drop_cnt", 64'(drop_cnt_o), 64'd2);
        repeat (16) step(idle, idle, 1'b1);
        step(mk(1, 0, 64'h3000), idle, 1'b1);
        step(idle, idle, 1'b1);
        step(idle, idle, 1'b1);

        // Overflow, partial drain to 7, then asynchronous reset and a fresh push.
        do_reset();
        for (int c = 0; c < 9; c++)
            step(mk(1, 0, 64'h4000 + 64'(16 * c)), mk(0, 1, 64'h4008 + 64'(16 * c)), 1'b0);
        repeat (9) step(idle, idle, 1'b1);
        @(negedge clk_i);
        check("pre_rst_count", 64'(count_o), 64'(model_count));
        check("pre_rst_overflow", 64'(overflow_o), 64'(model_ovf));
        do_reset();
        step(mk(1, 0, 64'h5000), idle, 1'b1);
        repeat (3) step(idle, idle, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_serializer.md
# rvfi_serializer

Commit-side buffer between the core's multi-port RVFI output and single-port consumers (tracer, co-simulation checker). Each cycle it captures every retired or trapping record on the `NR_COMMIT_PORTS` RVFI ports and compacts them in port order into a FIFO. It then emits them one per cycle, in program order, over a valid/ready handshake, tagging each record with a 64-bit sequence number. RVFI has no backpressure, so overflow is detected and reported, never stalled.

## Interface
- `NR_COMMIT_PORTS`, 2: number of RVFI commit ports; 1..4.
- `DEPTH`, 16: FIFO entries; power of two, ≥ 2*`NR_COMMIT_PORTS`.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `rvfi_i` in `rvfi_pkg::rvfi_instr_t[NR_COMMIT_PORTS-1:0]`: commit records; lower index is older.
- `valid_o` out 1: head entry available.
- `ready_i` in 1: consumer accepts head.
- `rvfi_o` out `rvfi_pkg::rvfi_instr_t`: head record.
- `seq_o` out 64: sequence number of head record.
- `count_o` out $clog2(DEPTH)+1: current occupancy.
- `overflow_o` out 1: sticky; set on the first dropped cycle.
- `drop_cnt_o` out 32: number of records dropped; saturates at 32'hFFFF_FFFF.

## Operation
- Port i is captured when `rvfi_i[i].valid | rvfi_i[i].trap`. Let k = the number of captured ports this cycle.
- Compaction: captured records are written to tail, tail+1, … in ascending port order. Gaps between ports are removed.
- Space check uses the registered `count_o` only. A same-cycle pop does not free space for a same-cycle push.
- If DEPTH − `count_o` ≥ k: all k are written, tail += k, and each record gets seq = `seq_ctr` + its compacted index.
- Otherwise, all k records of that cycle are dropped (no partial writes), `overflow_o` is set, and `drop_cnt_o` += k (saturating).
- `seq_ctr` advances by k every cycle, written or dropped. Drops therefore appear as gaps in `seq_o`.
- Pop on `valid_o & ready_i`: head += 1.
- `count_o` next = `count_o` + (written ? k : 0) − pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- `valid_o` = (`count_o` != 0). `rvfi_o` and `seq_o` are read combinationally from the head entry and are don't-care when `valid_o` = 0.
- Simultaneous push and pop on a full FIFO: the push is dropped (space check rule) and the pop proceeds.
- Simultaneous push and pop with `count_o` = 1: the head advances and the new entries remain.

## Timing
- Reset values: `valid_o`=0, `count_o`=0, `overflow_o`=0, `drop_cnt_o`=0, `seq_o`=0, `rvfi_o`='0. Head, tail and `seq_ctr` reset to 0.
- Latency: a record captured at edge N is visible on `rvfi_o`/`valid_o` after edge N, i.e. usable in cycle N+1 if the FIFO was empty.
- Throughput: 1 record/cycle out; up to `NR_COMMIT_PORTS` records/cycle in.
- Handshake: `valid_o` never drops without a pop. `rvfi_o` and `seq_o` are stable while `valid_o & ~ready_i`.
- Reset mid-operation discards all contents asynchronously and clears `overflow_o`.

## Configuration
- `RVFI_SERIALIZER_CYCLE_STAMP_EN` defined: adds output port `cycle_o` [63:0] and a free-running 64-bit cycle counter (reset 0, +1 per cycle).
  - Each entry stores the counter value at its capture edge. `cycle_o` presents the head entry's stamp; records from the same cycle share a stamp.
- `RVFI_SERIALIZER_CYCLE_STAMP_EN` undefined: no port, no counter, no storage for stamps.

## Structure
- `rvfi_pkg` gains `rvfi_ser_entry_t` (instr, seq, optional cycle stamp) and `RVFI_SER_SEQ_W = 64`.
- One sub-module, `rvfi_ser_compact`: combinational. It takes the port vector and produces the compacted record array plus k.
- FIFO storage, pointers and counters are in the top module.

## Test plan
- Single port valid, `ready_i`=1: `rvfi_o.pc_rdata`=0x8000_0000 one cycle after capture, `seq_o`=0, `count_o` returns to 0.
- Ports 0 and 1 valid with pc 0x100/0x104, ports valid again with 0x108/0x10C, `ready_i`=1: outputs 0x100, 0x104, 0x108, 0x10C with seq 0,1,2,3 on consecutive cycles.
- Port 0 idle, port 1 `trap`=1 at pc 0x200: single entry 0x200 with `trap`=1, `seq_o`=0.
- `ready_i`=0, two records per cycle for 9 cycles with DEPTH=16: first 8 cycles accepted (`count_o`=16). Cycle 9 is dropped: `overflow_o`=1, `drop_cnt_o`=2. After draining, seq reads 0..15, then the next accepted record is 18.
- Hold `ready_i`=0 with `valid_o`=1 for 5 cycles: `rvfi_o` and `seq_o` remain constant. Raise `ready_i`: exactly one pop per cycle.
- Assert `rst_ni`=0 asynchronously with `count_o`=7 and `overflow_o`=1: all outputs immediately reach their reset values. The next push gets `seq_o`=0.
